// File: rtl/mio_bus_responder_if.sv
// CPU memory/IO bus between the CPU data port (master) and the responder (slave).
interface mio_bus_responder_if;
    logic        CPU_MIO;
    logic        MemRW;
    logic [31:0] Addr_in;
    logic [31:0] Data_in;
    logic [31:0] Data_out;
    logic        MIO_ready;
    logic        bus_err;

    modport master (
        output CPU_MIO, MemRW, Addr_in, Data_in,
        input  Data_out, MIO_ready, bus_err
    );

    modport slave (
        input  CPU_MIO, MemRW, Addr_in, Data_in,
        output Data_out, MIO_ready, bus_err
    );
endinterface

// File: rtl/mio_bus_responder.sv
// Bus responder: captures one CPU access, waits WAIT_CYCLES, then serves it from
// word RAM (0x0), the LED register (0xE) or the cycle counter (0xF).
module mio_bus_responder #(
    parameter int RAM_AW      = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int LED_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mio_bus_responder_if.slave   bus,
    output logic [LED_W-1:0]     LED_out,
    output logic [31:0]          counter_out
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              capture, do_access;

    logic [31:0]       addr_p0, wdata_p0;
    logic              we_p0;
    logic [31:0]       mem [2**RAM_AW];
    logic [31:0]       data_out_q, counter_q, rd_data;
    logic [LED_W-1:0]  led_q;
    logic              bus_err_q;
    logic [3:0]        region;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_addr_bits;

    function automatic logic [31:0] led_ext(input logic [LED_W-1:0] v);
        logic [31:0] r;
        r = '0;
        r[LED_W-1:0] = v;
        return r;
    endfunction

    assign region           = addr_p0[31:28];
    assign ram_idx          = addr_p0[RAM_AW+1:2];
    assign unused_addr_bits = ^addr_p0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (bus.CPU_MIO) begin
                    capture   = 1'b1;
                    cnt_nxt   = 4'(WAIT_CYCLES);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    do_access = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read source at the access edge; the counter read sees its post-increment value.
    always_comb begin
        rd_data = 32'h0;
        case (region)
            4'h0:    rd_data = mem[ram_idx];
            4'hE:    rd_data = led_ext(led_q);
            4'hF:    rd_data = counter_q + 32'd1;
            default: rd_data = 32'h0;
        endcase
    end

    // Stage p0: captured request, authoritative for the rest of the transaction.
    always_ff @(posedge clk) begin
        if (capture) begin
            addr_p0  <= bus.Addr_in;
            wdata_p0 <= bus.Data_in;
            we_p0    <= bus.MemRW;
        end
    end

    always_ff @(posedge clk) begin
        if (do_access && we_p0 && region == 4'h0) begin
            mem[ram_idx] <= wdata_p0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            data_out_q <= 32'h0;
            led_q      <= '0;
            counter_q  <= 32'h0;
            bus_err_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bus_err_q <= do_access && (region != 4'h0) && (region != 4'hE) && (region != 4'hF);
            if (do_access && we_p0 && region == 4'hF) begin
                counter_q <= wdata_p0;
            end else begin
                counter_q <= counter_q + 32'd1;
            end
            if (do_access) begin
                if (we_p0) begin
                    if (region == 4'hE) begin
                        led_q <= wdata_p0[LED_W-1:0];
                    end
                end else begin
                    data_out_q <= rd_data;
                end
            end
        end
    end

    assign bus.MIO_ready = (state == RESP);
    assign bus.bus_err   = bus_err_q;
    assign bus.Data_out  = data_out_q;
    assign LED_out       = led_q;
    assign counter_out   = counter_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Scoreboard bench for mio_bus_responder: directed accesses push expected responses,
// a negedge monitor pops them whenever MIO_ready is presented.
module tb_mio_bus_responder;
    localparam int WAIT_CYCLES = 2;
    localparam int LED_W       = 16;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] led_out;
    logic [31:0] counter_out;
    int          n_cmp;
    int          n_fail;
    int          edge_cnt;
    exp_t        sb_q[$];
    logic [31:0] model_dout;
    logic [31:0] rdy_counter;
    int          last_acc_edge;

    mio_bus_responder_if bus();

    mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(WAIT_CYCLES), .LED_W(LED_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .LED_out     (led_out),
        .counter_out (counter_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per MIO_ready cycle.
    always @(negedge clk) begin
        if (rst && bus.MIO_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_data", bus.Data_out, e.data);
                chk("sb_bus_err", {31'd0, bus.bus_err}, {31'd0, e.err});
            end
        end else if (bus.bus_err) begin
            chk("bus_err_without_ready", 32'd1, 32'd0);
        end
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd_exp, input logic err_exp);
        int acc;
        bit seen;
        exp_t e;
        if (!we) model_dout = rd_exp;
        e.data = model_dout;
        e.err  = err_exp;
        sb_q.push_back(e);
        @(negedge clk);
        bus.CPU_MIO = 1'b1;
        bus.MemRW   = we;
        bus.Addr_in = addr;
        bus.Data_in = wdata;
        @(posedge clk);
        #1;
        acc = edge_cnt;
        bus.CPU_MIO = 1'b0;
        bus.MemRW   = ~we;
        bus.Addr_in = ~addr;
        bus.Data_in = ~wdata;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.MIO_ready) seen = 1;
        end
        if (!seen) begin
            chk("timeout_ready", 32'd0, 32'd1);
        end else begin
            chk("latency", edge_cnt, acc + WAIT_CYCLES + 1);
            last_acc_edge = edge_cnt;
            rdy_counter   = counter_out;
            @(negedge clk);
            chk("ready_one_cycle", {31'd0, bus.MIO_ready}, 32'd0);
        end
    endtask

    initial begin
        int pulses[3];
        int np;
        logic [31:0] off;
        n_cmp = 0;
        n_fail = 0;
        model_dout = 32'h0;
        rst = 1'b0;
        bus.CPU_MIO = 1'b0;
        bus.MemRW   = 1'b0;
        bus.Addr_in = 32'h0;
        bus.Data_in = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, bus.MIO_ready}, 32'd0);
        chk("rst_err", {31'd0, bus.bus_err}, 32'd0);
        chk("rst_dout", bus.Data_out, 32'h0);
        chk("rst_led", {16'd0, led_out}, 32'h0);
        chk("rst_counter", counter_out, 32'h0);
        rst = 1'b1;

        // RAM write then read-back
        access(1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, 1'b0);
        access(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0);

        // LED register
        access(1'b1, 32'hE000_0000, 32'hFFFF_A5A5, 32'h0, 1'b0);
        chk("led_write", {16'd0, led_out}, 32'h0000_A5A5);
        access(1'b0, 32'hE000_0000, 32'h0, 32'h0000_A5A5, 1'b0);

        // Counter load, read 5 edges later, and wrap
        access(1'b1, 32'hF000_0000, 32'h0000_0100, 32'h0, 1'b0);
        chk("counter_load", rdy_counter, 32'h0000_0100);
        while (edge_cnt < last_acc_edge + 3) @(negedge clk);
        access(1'b0, 32'hF000_0000, 32'h0, 32'h0000_0100 + 5 + WAIT_CYCLES + 1, 1'b0);
        access(1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
        chk("counter_full", rdy_counter, 32'hFFFF_FFFF);
        chk("counter_wrap", counter_out, 32'h0);

        // Unmapped region
        access(1'b0, 32'h5000_0000, 32'h0, 32'h0, 1'b1);
        off = counter_out - 32'(edge_cnt);
        access(1'b1, 32'h5000_0010, 32'hCAFE_F00D, 32'h0, 1'b1);
        chk("unmapped_led", {16'd0, led_out}, 32'h0000_A5A5);
        chk("unmapped_counter", counter_out - 32'(edge_cnt), off);
        access(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0);

        // Back-to-back with CPU_MIO held high
        model_dout = 32'h0000_A5A5;
        for (int i = 0; i < 3; i++) sb_q.push_back('{data: 32'h0000_A5A5, err: 1'b0});
        @(negedge clk);
        bus.CPU_MIO = 1'b1;
        bus.MemRW   = 1'b0;
        bus.Addr_in = 32'hE000_0000;
        np = 0;
        for (int i = 0; i < 40 && np < 3; i++) begin
            @(negedge clk);
            if (bus.MIO_ready) begin
                pulses[np] = edge_cnt;
                np++;
            end
        end
        bus.CPU_MIO = 1'b0;
        chk("b2b_count", np, 3);
        if (np == 3) begin
            chk("b2b_gap1", pulses[1] - pulses[0], WAIT_CYCLES + 3);
            chk("b2b_gap2", pulses[2] - pulses[1], WAIT_CYCLES + 3);
        end
        repeat (2) @(negedge clk);

        // Reset mid-WAIT during a RAM write
        bus.CPU_MIO = 1'b1;
        bus.MemRW   = 1'b1;
        bus.Addr_in = 32'h0000_0010;
        bus.Data_in = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.CPU_MIO = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready", {31'd0, bus.MIO_ready}, 32'd0);
        chk("abort_led", {16'd0, led_out}, 32'h0);
        chk("abort_counter", counter_out, 32'h0);
        chk("abort_dout", bus.Data_out, 32'h0);
        repeat (2) @(negedge clk);
        chk("abort_no_ready", {31'd0, bus.MIO_ready}, 32'd0);
        rst = 1'b1;
        model_dout = 32'h0;
        access(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
